// File: rtl/fwd_hazard_if.sv
// rtl/fwd_hazard_if.sv - pipeline-side bundle for the forwarding/hazard unit
// Purpose: groups the ID-stage operand info, the EX/MEM/WB producer info and
//          the unit's stall/bypass/forward outputs.
// Ports (signals):
//   id_valid, id_src, id_src_used        ID-stage instruction and its sources
//   ex_regwrt, ex_is_load, ex_dest       producer in EX
//   mem_regwrt, mem_dest                 producer in MEM
//   wb_regwrt, wb_dest                   producer in WB
//   flush                                branch/exception flush of ID and EX
//   stall, rf_bypass, fwd_sel,
//   stall_cycles                         outputs of the hazard unit
// Modports: master = pipeline driving producers, slave = hazard unit.
interface fwd_hazard_if #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      ex_regwrt;
  logic                      ex_is_load;
  logic [REG_AW-1:0]         ex_dest;
  logic                      mem_regwrt;
  logic [REG_AW-1:0]         mem_dest;
  logic                      wb_regwrt;
  logic [REG_AW-1:0]         wb_dest;
  logic                      flush;
  logic                      stall;
  logic [NUM_SRC-1:0]        rf_bypass;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    output id_valid, id_src, id_src_used,
    output ex_regwrt, ex_is_load, ex_dest,
    output mem_regwrt, mem_dest, wb_regwrt, wb_dest, flush,
    input  stall, rf_bypass, fwd_sel, stall_cycles
  );

  modport slave (
    input  id_valid, id_src, id_src_used,
    input  ex_regwrt, ex_is_load, ex_dest,
    input  mem_regwrt, mem_dest, wb_regwrt, wb_dest, flush,
    output stall, rf_bypass, fwd_sel, stall_cycles
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select and load-use hazard unit
// Purpose: compares ID-stage sources against EX/MEM/WB producers, registers a
//          forwarding select per source into EX, stalls ID on load-use
//          hazards for LOAD_LAT cycles and drives a same-cycle WB->ID bypass.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fwd_hazard_if.slave (producer info in, stall/bypass/fwd_sel/
//          stall_cycles out)
module fwd_hazard_unit #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          rst_n,
  fwd_hazard_if.slave  bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;
  localparam logic [2:0] LAT_M1   = 3'(LOAD_LAT - 1);

  logic [0:0]           state;
  logic [2:0]           cnt;
  logic [NUM_SRC-1:0]   m_ex;
  logic [NUM_SRC-1:0]   m_mem;
  logic [NUM_SRC-1:0]   m_wb;
  logic                 hazard;
  logic                 stall_int;
  logic [2*NUM_SRC-1:0] fwd_nxt;
  logic [2*NUM_SRC-1:0] fwd_q;
  logic [CNT_W-1:0]     cyc_q;

  // Per-source producer matches; a source counts only when it is really read
  // and is not the hardwired zero register.
  always_comb begin
    m_ex  = '0;
    m_mem = '0;
    m_wb  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [REG_AW-1:0] src;
      logic              live;
      src  = bus.id_src[i*REG_AW +: REG_AW];
      live = bus.id_valid & bus.id_src_used[i] & !((ZERO_REG != 0) && (src == '0));
      m_ex[i]  = live & bus.ex_regwrt  & (bus.ex_dest  == src);
      m_mem[i] = live & bus.mem_regwrt & (bus.mem_dest == src);
      m_wb[i]  = live & bus.wb_regwrt  & (bus.wb_dest  == src);
    end
  end

  assign hazard    = (|m_ex) & bus.ex_is_load;
  assign stall_int = (state == ST_STALL) | hazard;

  // Reset clears state asynchronously, but a live hazard would still assert
  // stall combinationally; gate it so the pipeline sees no stall in reset.
  assign bus.stall     = rst_n & stall_int;
  assign bus.rf_bypass = m_wb;

  // EX producer is younger than MEM, so it wins; a stalled, flushed or empty
  // ID stage becomes a bubble with select 0.
  always_comb begin
    fwd_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (stall_int | bus.flush | !bus.id_valid) begin
        fwd_nxt[2*i +: 2] = 2'd0;
      end else if (m_ex[i]) begin
        fwd_nxt[2*i +: 2] = 2'd1;
      end else if (m_mem[i]) begin
        fwd_nxt[2*i +: 2] = 2'd2;
      end else begin
        fwd_nxt[2*i +: 2] = 2'd0;
      end
    end
  end

  // RUN covers the first hazard cycle itself; STALL holds the remaining
  // LOAD_LAT-1 cycles regardless of what ID shows meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else if (bus.flush) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state <= ST_STALL;
            cnt   <= LAT_M1;
          end
        end
        ST_STALL: begin
          if (cnt == 3'd1) begin
            state <= ST_RUN;
          end
          cnt <= cnt - 3'd1;
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q <= '0;
    end else begin
      fwd_q <= fwd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (stall_int && !(&cyc_q)) begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

  assign bus.fwd_sel      = fwd_q;
  assign bus.stall_cycles = cyc_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid;
  logic [7:0] id_src;
  logic [1:0] id_src_used;
  logic       ex_regwrt, ex_is_load, mem_regwrt, wb_regwrt, flush;
  logic [3:0] ex_dest, mem_dest, wb_dest;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_if #(.REG_AW(4), .NUM_SRC(2), .CNT_W(4)) if1 ();
  fwd_hazard_if #(.REG_AW(4), .NUM_SRC(2), .CNT_W(4)) if3 ();

  assign if1.id_valid = id_valid;     assign if3.id_valid = id_valid;
  assign if1.id_src = id_src;         assign if3.id_src = id_src;
  assign if1.id_src_used = id_src_used; assign if3.id_src_used = id_src_used;
  assign if1.ex_regwrt = ex_regwrt;   assign if3.ex_regwrt = ex_regwrt;
  assign if1.ex_is_load = ex_is_load; assign if3.ex_is_load = ex_is_load;
  assign if1.ex_dest = ex_dest;       assign if3.ex_dest = ex_dest;
  assign if1.mem_regwrt = mem_regwrt; assign if3.mem_regwrt = mem_regwrt;
  assign if1.mem_dest = mem_dest;     assign if3.mem_dest = mem_dest;
  assign if1.wb_regwrt = wb_regwrt;   assign if3.wb_regwrt = wb_regwrt;
  assign if1.wb_dest = wb_dest;       assign if3.wb_dest = wb_dest;
  assign if1.flush = flush;           assign if3.flush = flush;

  fwd_hazard_unit #(.REG_AW(4), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(4))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  fwd_hazard_unit #(.REG_AW(4), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG(1), .CNT_W(4))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  // ---------------- behavioural model ----------------
  // rem[k] = forced stall cycles still owed after the current one.
  int         rem [2];
  logic [3:0] cnt_m [2];
  logic [3:0] fsel_m [2];
  logic       m_st;

  function automatic logic mt(logic rw, logic [3:0] d, int i);
    logic [3:0] s;
    s = id_src[i*4 +: 4];
    return rw && id_valid && id_src_used[i] && (d == s) && (s != 4'd0);
  endfunction

  function automatic logic hz();
    return ex_is_load && (mt(ex_regwrt, ex_dest, 0) || mt(ex_regwrt, ex_dest, 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        rem[k] = 0; cnt_m[k] = 4'd0; fsel_m[k] = 4'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_st = (rem[k] > 0) || hz();
        for (int i = 0; i < 2; i++) begin
          if (m_st || flush || !id_valid) fsel_m[k][2*i +: 2] = 2'd0;
          else if (mt(ex_regwrt, ex_dest, i)) fsel_m[k][2*i +: 2] = 2'd1;
          else if (mt(mem_regwrt, mem_dest, i)) fsel_m[k][2*i +: 2] = 2'd2;
          else fsel_m[k][2*i +: 2] = 2'd0;
        end
        if (m_st && cnt_m[k] != 4'hF) cnt_m[k] = cnt_m[k] + 4'd1;
        if (flush) rem[k] = 0;
        else if (rem[k] > 0) rem[k] = rem[k] - 1;
        else if (hz()) rem[k] = (k == 0) ? 0 : 2;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_k(input int k, input logic st, input logic [1:0] byp,
                       input logic [3:0] fs, input logic [3:0] sc);
    logic st_e;
    logic [1:0] byp_e;
    st_e  = rst_n && ((rem[k] > 0) || hz());
    byp_e = {mt(wb_regwrt, wb_dest, 1), mt(wb_regwrt, wb_dest, 0)};
    chk($sformatf("model_stall_%0d", k), int'(st), int'(st_e));
    chk($sformatf("model_bypass_%0d", k), int'(byp), int'(byp_e));
    chk($sformatf("model_fwd_sel_%0d", k), int'(fs), int'(fsel_m[k]));
    chk($sformatf("model_stall_cycles_%0d", k), int'(sc), int'(cnt_m[k]));
  endtask

  always @(negedge clk) begin
    cmp_k(0, if1.stall, if1.rf_bypass, if1.fwd_sel, if1.stall_cycles);
    cmp_k(1, if3.stall, if3.rf_bypass, if3.fwd_sel, if3.stall_cycles);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 1'b0; id_src = 8'h00; id_src_used = 2'b00;
    ex_regwrt = 1'b0; ex_is_load = 1'b0; ex_dest = 4'd0;
    mem_regwrt = 1'b0; mem_dest = 4'd0;
    wb_regwrt = 1'b0; wb_dest = 4'd0; flush = 1'b0;
  endtask

  task automatic load_use(input logic [3:0] r);
    clr();
    id_valid = 1'b1; id_src = {r, 4'd1}; id_src_used = 2'b10;
    ex_regwrt = 1'b1; ex_is_load = 1'b1; ex_dest = r;
  endtask

  task automatic load_in_mem(input logic [3:0] r);
    clr();
    id_valid = 1'b1; id_src = {r, 4'd1}; id_src_used = 2'b10;
    mem_regwrt = 1'b1; mem_dest = r;
  endtask

  initial begin
    // reset with a live load-use hazard on the inputs
    load_use(4'd5);
    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_stall1", int'(if1.stall), 0);
    chk("reset_stall3", int'(if3.stall), 0);
    chk("reset_fwd_sel", int'(if1.fwd_sel), 0);
    chk("reset_stall_cycles", int'(if1.stall_cycles), 0);
    clr();
    #2 rst_n = 1'b1;
    tick();

    // priority: EX over MEM, then MEM once EX stops writing
    id_valid = 1'b1; id_src = 8'h13; id_src_used = 2'b01;
    ex_regwrt = 1'b1; ex_dest = 4'd3; mem_regwrt = 1'b1; mem_dest = 4'd3;
    tick();
    chk("prio_ex", int'(if1.fwd_sel[1:0]), 1);
    ex_regwrt = 1'b0;
    tick();
    chk("prio_mem", int'(if1.fwd_sel[1:0]), 2);
    clr(); tick();

    // load-use with LOAD_LAT=1: one stall cycle, then MEM forward
    load_use(4'd5);
    #1 chk("lat1_stall_on", int'(if1.stall), 1);
    tick();
    load_in_mem(4'd5);
    #1 chk("lat1_stall_off", int'(if1.stall), 0);
    tick();
    chk("lat1_fwd_mem", int'(if1.fwd_sel[3:2]), 2);
    chk("lat1_stall_cycles", int'(if1.stall_cycles), 1);
    clr(); repeat (4) tick();

    // load-use with LOAD_LAT=3: three stall cycles, bubbles throughout
    load_use(4'd5);
    #1 chk("lat3_c0", int'(if3.stall), 1);
    tick();
    load_in_mem(4'd5);
    chk("lat3_c1", int'(if3.stall), 1);
    chk("lat3_c1_fwd", int'(if3.fwd_sel), 0);
    tick();
    chk("lat3_c2", int'(if3.stall), 1);
    chk("lat3_c2_fwd", int'(if3.fwd_sel), 0);
    tick();
    chk("lat3_c3", int'(if3.stall), 0);
    chk("lat3_c3_fwd", int'(if3.fwd_sel), 0);
    clr(); repeat (2) tick();

    // flush on the second stall cycle cuts the stall short
    load_use(4'd6);
    tick();
    load_in_mem(4'd6);
    flush = 1'b1;
    #1 chk("flush_c1_stall", int'(if3.stall), 1);
    tick();
    flush = 1'b0;
    #1 chk("flush_c2_stall", int'(if3.stall), 0);
    chk("flush_fwd", int'(if3.fwd_sel), 0);
    clr(); repeat (2) tick();

    // async reset while in STALL
    load_use(4'd4);
    tick();
    clr();
    #1 chk("pre_reset_stall", int'(if3.stall), 1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_stall", int'(if3.stall), 0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_reset_stall", int'(if3.stall), 0);

    // zero register and unused source never match
    clr();
    id_valid = 1'b1; id_src = 8'h20; id_src_used = 2'b01;
    ex_regwrt = 1'b1; ex_is_load = 1'b1; ex_dest = 4'd0;
    #1 chk("zero_no_stall", int'(if1.stall), 0);
    tick();
    chk("zero_fwd", int'(if1.fwd_sel), 0);
    id_src = 8'h26; id_src_used = 2'b00; ex_is_load = 1'b0; ex_dest = 4'd6;
    tick();
    chk("unused_fwd", int'(if1.fwd_sel), 0);

    // WB bypass is visible the same cycle
    clr();
    id_valid = 1'b1; id_src = 8'h72; id_src_used = 2'b11;
    wb_regwrt = 1'b1; wb_dest = 4'd7;
    #1 chk("wb_bypass", int'(if1.rf_bypass), 2);
    tick();

    // saturation: 2^4+5 continuous stall cycles
    load_use(4'd5);
    repeat (21) tick();
    chk("sat_cnt1", int'(if1.stall_cycles), 15);
    chk("sat_cnt3", int'(if3.stall_cycles), 15);
    clr(); repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
